// File: rtl/task_reg_bank_pkg.sv
// Shared types and default addresses for the task request register bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package task_reg_bank_pkg;

    // Per-channel handshake state; encodings are fixed so status decode stays stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } chan_state_e;

    localparam int          DEF_N_TASKS  = 16;
    localparam int          DEF_TOUT_W   = 16;
    localparam logic [11:0] DEF_TASK_ADR = 12'hffe;
    localparam logic [11:0] DEF_PEND_ADR = 12'hffd;
    localparam logic [11:0] DEF_STAT_ADR = 12'hffc;

endpackage

// File: rtl/task_reg_bank_if.sv
// Register bus plus per-channel task handshake bundle between bus master, bank and task logic.
// Latency: n/a (wires only).
// Backpressure: none; the task logic throttles each channel through its ack.
interface task_reg_bank_if
    import task_reg_bank_pkg::*;
#(
    parameter int P_N_TASKS = DEF_N_TASKS
);
    logic [11:0]          adr;
    logic                 wr;
    logic [P_N_TASKS-1:0] data;
    logic [P_N_TASKS-1:0] rd_data;
    logic [P_N_TASKS-1:0] req;
    logic [P_N_TASKS-1:0] ack;
    logic [P_N_TASKS-1:0] val;
    logic [P_N_TASKS-1:0] pend;
    logic [P_N_TASKS-1:0] tout;

    // Environment side: drives the bus and the task acknowledges.
    modport master (
        output adr, wr, data, ack,
        input  rd_data, req, val, pend, tout
    );

    // Register bank side.
    modport slave (
        input  adr, wr, data, ack,
        output rd_data, req, val, pend, tout
    );
endinterface

// File: rtl/task_chan.sv
// One task channel: IDLE/REQ/ACK handshake FSM with a one-deep request queue and optional watchdog (TASK_REG_BANK_TIMEOUT_EN).
// Latency: launch visible one edge after the write; req drops one edge after ack rises; idle one edge after ack falls.
// Backpressure: requests during a busy handshake queue one deep and further ones coalesce; REQ holds until ack (or watchdog expiry).
module task_chan
    import task_reg_bank_pkg::*;
#(
    parameter int                  P_TOUT_W = DEF_TOUT_W,
    parameter logic [P_TOUT_W-1:0] P_TOUT   = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic launch_i,
    input  logic ack_i,
    input  logic ack_fall_i,
    input  logic clr_i,
    output logic req_o,
    output logic val_o,
    output logic pend_o,
    output logic tout_o
);
    chan_state_e state_q;
    logic        req_q;
    logic        val_q;
    logic        pend_q;
`ifdef TASK_REG_BANK_TIMEOUT_EN
    logic [P_TOUT_W-1:0] cnt_q;
    logic                tout_q;
`endif

    // Handshake FSM; req/val are registered alongside the state so outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            val_q   <= 1'b0;
            pend_q  <= 1'b0;
`ifdef TASK_REG_BANK_TIMEOUT_EN
            cnt_q   <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
`ifdef TASK_REG_BANK_TIMEOUT_EN
            // Clear first so that an expiry later in this block overrides it.
            if (clr_i) begin
                tout_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    // ack while idle is deliberately ignored.
                    if (launch_i) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        val_q   <= 1'b1;
`ifdef TASK_REG_BANK_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ack_i) begin
                        // ack beats a watchdog expiry in the same cycle.
                        state_q <= ACK;
                        req_q   <= 1'b0;
                        if (launch_i) begin
                            pend_q <= 1'b1;
                        end
                    end
`ifdef TASK_REG_BANK_TIMEOUT_EN
                    else if (cnt_q == P_TOUT) begin
                        // Abort the stalled handshake and drop any queued request.
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        val_q   <= 1'b0;
                        pend_q  <= 1'b0;
                        tout_q  <= 1'b1;
                    end
`endif
                    else begin
                        if (launch_i) begin
                            pend_q <= 1'b1;
                        end
`ifdef TASK_REG_BANK_TIMEOUT_EN
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                ACK: begin
                    if (ack_fall_i) begin
                        if (pend_q || launch_i) begin
                            // Queued or coincident request relaunches straight away.
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            pend_q  <= 1'b0;
`ifdef TASK_REG_BANK_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                            val_q   <= 1'b0;
                        end
                    end else if (launch_i) begin
                        pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    val_q   <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_o  = req_q;
    assign val_o  = val_q;
    assign pend_o = pend_q;

`ifdef TASK_REG_BANK_TIMEOUT_EN
    assign tout_o = tout_q;
`else
    // Without the watchdog the clear strobe and limit have no effect.
    logic [P_TOUT_W:0] unused_wd;
    assign unused_wd = {clr_i, P_TOUT};
    assign tout_o    = 1'b0;
`endif

endmodule

// File: rtl/task_reg_bank.sv
// Task request register bank: bus-addressed launch of P_N_TASKS handshake channels with status readback; watchdog under TASK_REG_BANK_TIMEOUT_EN.
// Latency: channel outputs one edge after the triggering write/ack edge; rd_data one edge after adr.
// Backpressure: none on the bus (writes always accepted); per-channel one-deep queue, extra launches coalesce.
module task_reg_bank
    import task_reg_bank_pkg::*;
#(
    parameter int                  P_N_TASKS  = DEF_N_TASKS,
    parameter logic [11:0]         P_TASK_ADR = DEF_TASK_ADR,
    parameter logic [11:0]         P_PEND_ADR = DEF_PEND_ADR,
    parameter logic [11:0]         P_STAT_ADR = DEF_STAT_ADR,
    parameter int                  P_TOUT_W   = DEF_TOUT_W,
    parameter logic [P_TOUT_W-1:0] P_TOUT     = '1
) (
    input  logic           clk,
    input  logic           rst,
    task_reg_bank_if.slave bus
);
    logic                 task_wr;
    logic                 stat_wr;
    logic [P_N_TASKS-1:0] ack_prev_q;
    logic [P_N_TASKS-1:0] ack_fall;
    logic [P_N_TASKS-1:0] rd_data_q;
    logic [P_N_TASKS-1:0] rd_data_d;
    logic [P_N_TASKS-1:0] chan_req;
    logic [P_N_TASKS-1:0] chan_val;
    logic [P_N_TASKS-1:0] chan_pend;
    logic [P_N_TASKS-1:0] chan_tout;

    assign task_wr = bus.wr && (bus.adr == P_TASK_ADR);
`ifdef TASK_REG_BANK_TIMEOUT_EN
    assign stat_wr = bus.wr && (bus.adr == P_STAT_ADR);
`else
    assign stat_wr = 1'b0;
`endif

    assign ack_fall = ack_prev_q & ~bus.ack;

    // Track ack in every state so a falling edge is seen regardless of channel state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_prev_q <= '0;
        end else begin
            ack_prev_q <= bus.ack;
        end
    end

    for (genvar i = 0; i < P_N_TASKS; i++) begin : g_chan
        task_chan #(
            .P_TOUT_W (P_TOUT_W),
            .P_TOUT   (P_TOUT)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .launch_i   (task_wr & bus.data[i]),
            .ack_i      (bus.ack[i]),
            .ack_fall_i (ack_fall[i]),
            .clr_i      (stat_wr & bus.data[i]),
            .req_o      (chan_req[i]),
            .val_o      (chan_val[i]),
            .pend_o     (chan_pend[i]),
            .tout_o     (chan_tout[i])
        );
    end

    // Readback source select; unmapped addresses read as zero.
    always_comb begin
        rd_data_d = '0;
        case (bus.adr)
            P_TASK_ADR: rd_data_d = chan_val;
            P_PEND_ADR: rd_data_d = chan_pend;
            P_STAT_ADR: rd_data_d = chan_tout;
            default:    rd_data_d = '0;
        endcase
    end

    // Register the readback so it reflects state as of the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.req     = chan_req;
    assign bus.val     = chan_val;
    assign bus.pend    = chan_pend;
    assign bus.tout    = chan_tout;

endmodule
